piece_move_scheduler: RTL and testbench

- Control FSM that sequences the falling-piece datapath of the 12x12 block game.
- Arbitrates player buttons and the gravity tick into single-cycle move commands.
- Gates each command on the left/right/bottom bound flags and waits for them to settle after every command.
- Sequences lock, row clearing, spawn check and game-over; sits between the input synchronisers and the square/background datapath.

---
 rtl/game_ctrl_pkg.sv | 15 +
 rtl/btn_req_gen.sv | 29 ++
 rtl/piece_move_scheduler.sv | 114 +++++++++++
 tb/tb_piece_move_scheduler.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/game_ctrl_pkg.sv
// game_ctrl_pkg: shared grid constants, scheduler state encoding and row-priority helper.
package game_ctrl_pkg;
  localparam int GRID_COLS = 12;
  localparam int GRID_ROWS = 12;
  localparam int ROW_IDX_W = 4;

  typedef enum logic [2:0] {RUN, SETTLE, LOCK, CLEAR, SPAWN, OVER} state_t;

  // Highest set index wins: bottom rows (largest index) are cleared first.
  function automatic logic [ROW_IDX_W-1:0] top_row(input logic [GRID_ROWS-1:0] rows);
    top_row = '0;
    for (int i = 0; i < GRID_ROWS; i++)
      if (rows[i]) top_row = ROW_IDX_W'(i);
  endfunction
endpackage

// File: rtl/btn_req_gen.sv
// btn_req_gen: one-cycle request pulse on a button rising edge.
// Optional HOLD_REPEAT_EN: re-pulses every REPEAT_DIV cycles while held.
module btn_req_gen #(
  parameter int REPEAT_DIV = 6250000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic req
);
  logic prev;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) prev <= 1'b0;
    else prev <= btn;
`ifdef HOLD_REPEAT_EN
  localparam int CW = $clog2(REPEAT_DIV + 1);
  logic [CW-1:0] cnt;
  logic rep;
  assign rep = prev & (cnt == CW'(REPEAT_DIV));
  assign req = btn & (~prev | rep);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (!btn) cnt <= '0;
    else if (~prev | rep) cnt <= CW'(1);
    else cnt <= cnt + 1'b1;
`else
  assign req = btn & ~prev;
`endif
endmodule

// File: rtl/piece_move_scheduler.sv
// piece_move_scheduler: arbitrates buttons and gravity into bound-gated move commands,
// then sequences lock, row clearing, spawn check and game-over. Macro: HOLD_REPEAT_EN.
module piece_move_scheduler
  import game_ctrl_pkg::*;
#(
  parameter int GRAVITY_DIV = 25000000,
  parameter int SETTLE_CYC  = 2,
  parameter int REPEAT_DIV  = 6250000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 btn_left,
  input  logic                 btn_right,
  input  logic                 btn_down,
  input  logic                 left_bound,
  input  logic                 right_bound,
  input  logic                 down_bound,
  input  logic [GRID_ROWS-1:0] row_full,
  input  logic                 spawn_blocked,
  output logic                 cmd_left,
  output logic                 cmd_right,
  output logic                 cmd_down,
  output logic                 cmd_lock,
  output logic                 cmd_clear,
  output logic [ROW_IDX_W-1:0] clear_row,
  output logic                 game_over,
  output logic [15:0]          score
);
  localparam int GW = $clog2(GRAVITY_DIV);
  localparam int SW = $clog2(SETTLE_CYC) + 1;
  state_t state, ret;
  logic [GW-1:0] grav;
  logic [SW-1:0] scnt;
  logic pend_l, pend_r, pend_d, req_l, req_r, req_d;
  logic live, tick, clr_l, clr_r, clr_d;
  btn_req_gen #(.REPEAT_DIV(REPEAT_DIV)) u_left  (.clk(clk), .rst_n(rst_n), .btn(btn_left),  .req(req_l));
  btn_req_gen #(.REPEAT_DIV(REPEAT_DIV)) u_right (.clk(clk), .rst_n(rst_n), .btn(btn_right), .req(req_r));
  btn_req_gen #(.REPEAT_DIV(REPEAT_DIV)) u_down  (.clk(clk), .rst_n(rst_n), .btn(btn_down),  .req(req_d));
  assign live      = state != OVER;
  assign game_over = state == OVER;
  assign tick      = live & (grav == GW'(GRAVITY_DIV - 1));
  // Requests served or dropped by RUN this cycle, in priority order.
  assign clr_d = (state == RUN) & pend_d;
  assign clr_l = (state == RUN) & ~pend_d & pend_l;
  assign clr_r = (state == RUN) & ~pend_d & ~pend_l & pend_r;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RUN;
      ret       <= RUN;
      grav      <= '0;
      scnt      <= '0;
      pend_l    <= 1'b0;
      pend_r    <= 1'b0;
      pend_d    <= 1'b0;
      cmd_left  <= 1'b0;
      cmd_right <= 1'b0;
      cmd_down  <= 1'b0;
      cmd_lock  <= 1'b0;
      cmd_clear <= 1'b0;
      clear_row <= '0;
      score     <= '0;
    end else begin
      cmd_left  <= 1'b0;
      cmd_right <= 1'b0;
      cmd_down  <= 1'b0;
      cmd_lock  <= 1'b0;
      cmd_clear <= 1'b0;
      grav      <= tick ? '0 : live ? grav + 1'b1 : grav;
      scnt      <= (state == SETTLE) ? scnt + 1'b1 : '0;
      pend_d    <= (pend_d & ~clr_d) | (live & (req_d | tick));
      pend_l    <= (pend_l & ~clr_l) | (live & req_l);
      pend_r    <= (pend_r & ~clr_r) | (live & req_r);
      case (state)
        RUN: begin
          if (pend_d) begin
            if (down_bound) state <= LOCK;
            else begin
              cmd_down <= 1'b1;
              state    <= SETTLE;
              ret      <= RUN;
            end
          end else if (pend_l) begin
            if (!left_bound) begin
              cmd_left <= 1'b1;
              state    <= SETTLE;
              ret      <= RUN;
            end
          end else if (pend_r && !right_bound) begin
            cmd_right <= 1'b1;
            state     <= SETTLE;
            ret       <= RUN;
          end
        end
        SETTLE: if (scnt == SW'(SETTLE_CYC - 1)) state <= ret;
        LOCK: begin
          cmd_lock <= 1'b1;
          state    <= SETTLE;
          ret      <= CLEAR;
        end
        CLEAR: begin
          if (|row_full) begin
            cmd_clear <= 1'b1;
            clear_row <= top_row(row_full);
            score     <= (score == 16'hFFFF) ? score : score + 1'b1;
            state     <= SETTLE;
            ret       <= CLEAR;
          end else state <= SPAWN;
        end
        SPAWN: state <= spawn_blocked ? OVER : RUN;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_piece_move_scheduler.sv
// tb_piece_move_scheduler: scoreboard bench; stimulus queues expected commands with due cycles,
// a monitor pops and compares them. A second instance checks the gravity period alone.
module tb_piece_move_scheduler;
  logic clk = 1'b0, rst_n = 1'b0, rst_g = 1'b0;
  always #5 clk = ~clk;
  logic btn_left = 0, btn_right = 0, btn_down = 0;
  logic left_bound = 0, right_bound = 0, down_bound = 0, spawn_blocked = 0;
  logic [11:0] row_full = '0;
  logic cmd_left, cmd_right, cmd_down, cmd_lock, cmd_clear, game_over;
  logic [3:0] clear_row;
  logic [15:0] score;
  logic g_left, g_right, g_down, g_lock, g_clear, g_over;
  logic [3:0] g_row;
  logic [15:0] g_score;
  logic z = 1'b0;
  logic [11:0] z12 = '0;

  piece_move_scheduler #(.GRAVITY_DIV(50000), .SETTLE_CYC(2), .REPEAT_DIV(5)) dut (
    .clk(clk), .rst_n(rst_n), .btn_left(btn_left), .btn_right(btn_right), .btn_down(btn_down),
    .left_bound(left_bound), .right_bound(right_bound), .down_bound(down_bound),
    .row_full(row_full), .spawn_blocked(spawn_blocked),
    .cmd_left(cmd_left), .cmd_right(cmd_right), .cmd_down(cmd_down), .cmd_lock(cmd_lock),
    .cmd_clear(cmd_clear), .clear_row(clear_row), .game_over(game_over), .score(score));

  piece_move_scheduler #(.GRAVITY_DIV(8), .SETTLE_CYC(2), .REPEAT_DIV(5)) dut_g (
    .clk(clk), .rst_n(rst_g), .btn_left(z), .btn_right(z), .btn_down(z),
    .left_bound(z), .right_bound(z), .down_bound(z), .row_full(z12), .spawn_blocked(z),
    .cmd_left(g_left), .cmd_right(g_right), .cmd_down(g_down), .cmd_lock(g_lock),
    .cmd_clear(g_clear), .clear_row(g_row), .game_over(g_over), .score(g_score));

  typedef struct {int kind; int row; int score; int due;} exp_t;
  exp_t sb[$];
  int checks = 0, errors = 0, mc = 0;
  int glast = -1, gint = 0;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  task automatic expect_cmd(input int kind, input int due, input int row = 0, input int sc = 0);
    sb.push_back('{kind, row, sc, due});
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // kinds: 1 left, 2 right, 3 down, 4 lock, 5 clear
  always @(posedge clk) begin
    logic [4:0] cmds;
    int kind;
    exp_t e;
    mc++;
    #1;
    cmds = {cmd_clear, cmd_lock, cmd_down, cmd_right, cmd_left};
    if (cmds != 5'd0) begin
      kind = cmd_left ? 1 : cmd_right ? 2 : cmd_down ? 3 : cmd_lock ? 4 : 5;
      check("onehot", $countones(cmds), 1);
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_cmd: got kind %0d at cycle %0d expected none", kind, mc);
      end else begin
        e = sb.pop_front();
        check("cmd_kind", kind, e.kind);
        check("cmd_cycle", mc, e.due);
        if (e.kind == 5) begin
          check("clear_row", int'(clear_row), e.row);
          check("score", int'(score), e.score);
        end
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (g_left | g_right | g_lock | g_clear) begin
      checks++;
      errors++;
      $display("FAIL grav_other: got non-down command expected none");
    end
    if (g_down) begin
      if (glast >= 0 && gint < 10) begin
        check("grav_period", mc - glast, 8);
        gint++;
      end
      glast = mc;
    end
  end

  initial begin
    int k;
    step(3);
    check("rst_cmds", int'({cmd_clear, cmd_lock, cmd_down, cmd_right, cmd_left}), 0);
    check("rst_clear_row", int'(clear_row), 0);
    check("rst_game_over", int'(game_over), 0);
    check("rst_score", int'(score), 0);
    rst_n = 1;
    rst_g = 1;
    step(2);
    // left blocked: request dropped, no command even after the bound lifts
    left_bound = 1;
    btn_left = 1;
    step(3);
    btn_left = 0;
    step(3);
    left_bound = 0;
    step(6);
    // left free
    expect_cmd(1, mc + 2);
    btn_left = 1;
    step(3);
    btn_left = 0;
    step(4);
    // left and right together
    expect_cmd(1, mc + 2);
    expect_cmd(2, mc + 5);
    btn_left = 1;
    btn_right = 1;
    step(3);
    btn_left = 0;
    btn_right = 0;
    step(6);
    // lock and two clears
    down_bound = 1;
    row_full = 12'h900;
    k = mc;
    expect_cmd(4, k + 3);
    expect_cmd(5, k + 6, 11, 1);
    expect_cmd(5, k + 9, 8, 2);
    btn_down = 1;
    step(1);
    btn_down = 0;
    step(5);
    row_full = 12'h100;
    step(3);
    row_full = 12'h000;
    step(6);
    check("run_game_over", int'(game_over), 0);
    check("run_score", int'(score), 2);
    down_bound = 0;
    expect_cmd(1, mc + 2);
    btn_left = 1;
    step(2);
    btn_left = 0;
    step(5);
    // spawn blocked -> game over
    down_bound = 1;
    spawn_blocked = 1;
    k = mc;
    expect_cmd(4, k + 3);
    btn_down = 1;
    step(1);
    btn_down = 0;
    step(7);
    check("over_set", int'(game_over), 1);
    for (int i = 0; i < 10; i++) begin
      for (int j = 0; j < 10; j++) begin
        btn_left = 1'($urandom);
        btn_right = 1'($urandom);
        btn_down = 1'($urandom);
        step(1);
      end
      check("over_sticky", int'(game_over), 1);
    end
    btn_left = 0;
    btn_right = 0;
    btn_down = 0;
    @(posedge clk);
    #2 rst_n = 0;
    #1;
    check("async_rst_over", int'(game_over), 0);
    check("async_rst_score", int'(score), 0);
    step(2);
    spawn_blocked = 0;
    down_bound = 0;
    rst_n = 1;
    step(2);
    // held right button
    k = mc;
`ifdef HOLD_REPEAT_EN
    expect_cmd(2, k + 2);
    expect_cmd(2, k + 7);
    expect_cmd(2, k + 12);
    expect_cmd(2, k + 17);
`else
    expect_cmd(2, k + 2);
`endif
    btn_right = 1;
    step(20);
    btn_right = 0;
    step(5);
    // reset while settling after lock: the pending clear must never appear
    down_bound = 1;
    row_full = 12'h800;
    k = mc;
    expect_cmd(4, k + 3);
    btn_down = 1;
    step(1);
    btn_down = 0;
    step(3);
    rst_n = 0;
    step(3);
    rst_n = 1;
    step(10);
    check("abort_score", int'(score), 0);
    down_bound = 0;
    row_full = '0;
    step(5);
    check("sb_empty", sb.size(), 0);
    check("grav_intervals", gint, 10);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
